// File: rtl/lcd_spi_streamer_if.sv
// Queue-side handshake for lcd_spi_streamer: a wide (pixel) queue and a narrow
// (command/parameter) queue, both popped by a one-cycle read pulse.
interface lcd_spi_streamer_if #(
  parameter int WIDE_W   = 16,
  parameter int NARROW_W = 8
);
  logic                wide_empty;
  logic [WIDE_W-1:0]   wide_data;
  logic                wide_read;
  logic                nar_empty;
  logic [NARROW_W-1:0] nar_data;
  logic                nar_dc;
  logic                nar_read;

  modport master (
    input  wide_empty, wide_data, nar_empty, nar_data, nar_dc,
    output wide_read, nar_read
  );

  modport slave (
    output wide_empty, wide_data, nar_empty, nar_data, nar_dc,
    input  wide_read, nar_read
  );
endinterface

// File: rtl/lcd_spi_streamer.sv
// Streams words from two queues to an SPI (mode 0, MSB first) LCD panel,
// wide queue first, keeping CS low across back-to-back words.
module lcd_spi_streamer #(
  parameter int WIDE_W   = 16,
  parameter int NARROW_W = 8,
  parameter int DIV      = 1,
  parameter int CS_HOLD  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  lcd_spi_streamer_if.master fifo,
  output logic               lcd_busy,
  output logic               lcd_cs_n,
  output logic               lcd_dc,
  output logic               lcd_sclk,
  output logic               lcd_data
);
  localparam int BIT_CW  = $clog2(WIDE_W + 1);
  localparam int DIV_CW  = $clog2(DIV + 1);
  localparam int HOLD_CW = $clog2(CS_HOLD + 2);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t              state_reg, state_next;
  logic [WIDE_W-1:0]   shreg_reg, shreg_next;
  logic [BIT_CW-1:0]   bit_cnt_reg, bit_cnt_next;
  logic [DIV_CW-1:0]   div_cnt_reg, div_cnt_next;
  logic [HOLD_CW-1:0]  hold_cnt_reg, hold_cnt_next;
  logic                cs_n_reg, cs_n_next;
  logic                dc_reg, dc_next;
  logic                sclk_reg, sclk_next;
  logic                data_reg, data_next;
  logic                wide_read_reg, wide_read_next;
  logic                nar_read_reg, nar_read_next;
  logic                busy_reg, busy_next;
  logic                load;

  logic                wide_sel;
  logic                pending;
  logic [WIDE_W-1:0]   load_word;

  // Narrow words are left-aligned so the shifter always emits from the top bit.
  assign wide_sel  = !fifo.wide_empty;
  assign pending   = !fifo.wide_empty || !fifo.nar_empty;
  assign load_word = wide_sel ? fifo.wide_data
                              : (WIDE_W'(fifo.nar_data) << (WIDE_W - NARROW_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      shreg_reg     <= '0;
      bit_cnt_reg   <= '0;
      div_cnt_reg   <= '0;
      hold_cnt_reg  <= '0;
      cs_n_reg      <= 1'b1;
      dc_reg        <= 1'b0;
      sclk_reg      <= 1'b0;
      data_reg      <= 1'b0;
      wide_read_reg <= 1'b0;
      nar_read_reg  <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shreg_reg     <= shreg_next;
      bit_cnt_reg   <= bit_cnt_next;
      div_cnt_reg   <= div_cnt_next;
      hold_cnt_reg  <= hold_cnt_next;
      cs_n_reg      <= cs_n_next;
      dc_reg        <= dc_next;
      sclk_reg      <= sclk_next;
      data_reg      <= data_next;
      wide_read_reg <= wide_read_next;
      nar_read_reg  <= nar_read_next;
      busy_reg      <= busy_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    shreg_next     = shreg_reg;
    bit_cnt_next   = bit_cnt_reg;
    div_cnt_next   = div_cnt_reg;
    hold_cnt_next  = hold_cnt_reg;
    cs_n_next      = cs_n_reg;
    dc_next        = dc_reg;
    sclk_next      = sclk_reg;
    data_next      = data_reg;
    wide_read_next = 1'b0;
    nar_read_next  = 1'b0;
    load           = 1'b0;

    case (state_reg)
      IDLE: begin
        cs_n_next = 1'b1;
        sclk_next = 1'b0;
        data_next = 1'b0;
        load      = pending;
      end
      SHIFT: begin
        if (div_cnt_reg != '0) begin
          div_cnt_next = div_cnt_reg - DIV_CW'(1);
        end else if (!sclk_reg) begin
          sclk_next    = 1'b1;
          div_cnt_next = DIV_CW'(DIV - 1);
        end else if (bit_cnt_reg > BIT_CW'(1)) begin
          sclk_next    = 1'b0;
          shreg_next   = shreg_reg << 1;
          data_next    = shreg_reg[WIDE_W-2];
          bit_cnt_next = bit_cnt_reg - BIT_CW'(1);
          div_cnt_next = DIV_CW'(DIV - 1);
        end else if (pending) begin
          load = 1'b1;
        end else begin
          sclk_next     = 1'b0;
          data_next     = 1'b0;
          hold_cnt_next = HOLD_CW'(CS_HOLD);
          state_next    = HOLD;
        end
      end
      HOLD: begin
        if (pending) begin
          load = 1'b1;
        end else if (hold_cnt_reg == '0) begin
          cs_n_next  = 1'b1;
          state_next = IDLE;
        end else begin
          hold_cnt_next = hold_cnt_reg - HOLD_CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    // A load always lands on an sclk-low edge, so dc never moves under a high clock.
    if (load) begin
      wide_read_next = wide_sel;
      nar_read_next  = !wide_sel;
      shreg_next     = load_word;
      data_next      = load_word[WIDE_W-1];
      bit_cnt_next   = wide_sel ? BIT_CW'(WIDE_W) : BIT_CW'(NARROW_W);
      div_cnt_next   = DIV_CW'(DIV - 1);
      dc_next        = wide_sel ? 1'b1 : fifo.nar_dc;
      cs_n_next      = 1'b0;
      sclk_next      = 1'b0;
      state_next     = SHIFT;
    end

    busy_next = (state_next != IDLE);
  end

  assign fifo.wide_read = wide_read_reg;
  assign fifo.nar_read  = nar_read_reg;
  assign lcd_busy       = busy_reg;
  assign lcd_cs_n       = cs_n_reg;
  assign lcd_dc         = dc_reg;
  assign lcd_sclk       = sclk_reg;
  assign lcd_data       = data_reg;
endmodule

// File: tb/tb_lcd_spi_streamer.sv
// Bench for lcd_spi_streamer: queue models feed two instances (DIV=1, DIV=3);
// a monitor deserialises the DIV=1 panel bus against a scoreboard of expected words.
module tb_lcd_spi_streamer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n1, rst_n3;
  logic busy1, cs_n1, dc1, sclk1, data1;
  logic busy3, cs_n3, dc3, sclk3, data3;

  lcd_spi_streamer_if #(.WIDE_W(16), .NARROW_W(8)) f1 ();
  lcd_spi_streamer_if #(.WIDE_W(16), .NARROW_W(8)) f3 ();

  lcd_spi_streamer #(.WIDE_W(16), .NARROW_W(8), .DIV(1), .CS_HOLD(2)) dut1 (
    .clk(clk), .rst_n(rst_n1), .fifo(f1),
    .lcd_busy(busy1), .lcd_cs_n(cs_n1), .lcd_dc(dc1), .lcd_sclk(sclk1), .lcd_data(data1)
  );

  lcd_spi_streamer #(.WIDE_W(16), .NARROW_W(8), .DIV(3), .CS_HOLD(2)) dut3 (
    .clk(clk), .rst_n(rst_n3), .fifo(f3),
    .lcd_busy(busy3), .lcd_cs_n(cs_n3), .lcd_dc(dc3), .lcd_sclk(sclk3), .lcd_data(data3)
  );

  typedef struct packed {
    logic [4:0]  nbits;
    logic [15:0] word;
    logic        dc;
  } exp_t;

  typedef struct {
    string name;
    int    act;
    int    exp;
  } chk_t;

  exp_t        sb_q[$];
  chk_t        chk_q[$];
  logic [15:0] wq1[$];
  logic [8:0]  nq1[$];
  logic [15:0] wq3[$];

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int rd1_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string n, input int a, input int e);
    chk_t c;
    c.name = n;
    c.act  = a;
    c.exp  = e;
    chk_q.push_back(c);
  endfunction

  function automatic void sb_push(input logic [4:0] n, input logic [15:0] w, input logic d);
    exp_t e;
    e.nbits = n;
    e.word  = w;
    e.dc    = d;
    sb_q.push_back(e);
  endfunction

  // One falling edge: service pops, then present the current queue heads.
  task automatic tick();
    logic [8:0] nh;
    @(negedge clk);
    if (f1.wide_read) begin
      rd1_cnt++;
      chk("pop_wide1_nonempty", int'(wq1.size() != 0), 1);
      if (wq1.size() != 0) wq1.delete(0);
    end
    if (f1.nar_read) begin
      rd1_cnt++;
      chk("pop_nar1_nonempty", int'(nq1.size() != 0), 1);
      if (nq1.size() != 0) nq1.delete(0);
    end
    if (f3.wide_read) begin
      chk("pop_wide3_nonempty", int'(wq3.size() != 0), 1);
      if (wq3.size() != 0) wq3.delete(0);
    end
    nh            = (nq1.size() != 0) ? nq1[0] : 9'h000;
    f1.wide_empty = (wq1.size() == 0);
    f1.wide_data  = (wq1.size() != 0) ? wq1[0] : 16'h0000;
    f1.nar_empty  = (nq1.size() == 0);
    f1.nar_data   = nh[7:0];
    f1.nar_dc     = nh[8];
    f3.wide_empty = (wq3.size() == 0);
    f3.wide_data  = (wq3.size() != 0) ? wq3[0] : 16'h0000;
    f3.nar_empty  = 1'b1;
    f3.nar_data   = 8'h00;
    f3.nar_dc     = 1'b0;
  endtask

  task automatic wait_load1(input string n, output int t, output int cs_hi);
    bit seen;
    seen  = 1'b0;
    t     = 0;
    cs_hi = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      if (f1.wide_read || f1.nar_read) begin
        seen = 1'b1;
        t    = cyc;
      end else if (cs_n1) begin
        cs_hi++;
      end
    end
    if (!seen) chk({n, "_timeout"}, int'(seen), 1);
  endtask

  task automatic wait_cs_rise1(input string n, output int t, output int last_fall);
    bit   seen;
    logic prev;
    seen      = 1'b0;
    prev      = sclk1;
    t         = 0;
    last_fall = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      if (prev && !sclk1) last_fall = cyc;
      prev = sclk1;
      if (cs_n1) begin
        seen = 1'b1;
        t    = cyc;
      end
    end
    if (!seen) chk({n, "_timeout"}, int'(seen), 1);
  endtask

  // Monitor: the only process that compares and steps the counters.
  int          mon_cnt = 0;
  logic        mon_active = 1'b0;
  exp_t        mon_exp;
  logic [15:0] mon_word = 16'h0;
  logic        mon_dc = 1'b0;
  logic        mon_prev_sclk = 1'b0;
  logic        mon_prev_dc = 1'b0;
  chk_t        mon_c;

  initial forever begin
    @(negedge clk);
    while (chk_q.size() != 0) begin
      mon_c = chk_q.pop_front();
      checks++;
      if (mon_c.act != mon_c.exp) begin
        errors++;
        $display("FAIL %s: got %0d, expected %0d", mon_c.name, mon_c.act, mon_c.exp);
      end
    end
    if (!rst_n1) begin
      mon_cnt    = 0;
      mon_active = 1'b0;
    end else begin
      if (dc1 !== mon_prev_dc && sclk1) begin
        checks++;
        errors++;
        $display("FAIL dc_change_sclk_high: dc went %0b->%0b with sclk=1", mon_prev_dc, dc1);
      end
      if (sclk1 && !mon_prev_sclk) begin
        if (mon_cnt == 0) begin
          mon_word = 16'h0;
          mon_dc   = dc1;
          if (sb_q.size() != 0) begin
            mon_exp    = sb_q.pop_front();
            mon_active = 1'b1;
          end else begin
            mon_active = 1'b0;
            checks++;
            errors++;
            $display("FAIL unexpected_word: serial word started with empty scoreboard at cyc %0d", cyc);
          end
        end
        mon_word = {mon_word[14:0], data1};
        mon_cnt++;
        if (mon_active && mon_cnt == int'(mon_exp.nbits)) begin
          checks++;
          if (mon_word !== mon_exp.word || mon_dc !== mon_exp.dc || dc1 !== mon_exp.dc) begin
            errors++;
            $display("FAIL serial_word: got word=%h dc=%0b/%0b, expected word=%h dc=%0b",
                     mon_word, mon_dc, dc1, mon_exp.word, mon_exp.dc);
          end else begin
            $display("txn word=%h dc=%0b bits=%0d cyc=%0d", mon_word, mon_dc, mon_cnt, cyc);
          end
          mon_cnt    = 0;
          mon_active = 1'b0;
        end else if (!mon_active && mon_cnt == 16) begin
          mon_cnt = 0;
        end
      end
    end
    mon_prev_sclk = sclk1;
    mon_prev_dc   = dc1;
  end

  initial begin
    int t0, t1, t, lf, hi, rd_before;
    int hmin, hmax, lmin, lmax, run, edges, tend, tcs;
    logic prev;
    logic [15:0] cap;
    bit seen, done;

    rst_n1 = 1'b0;
    rst_n3 = 1'b0;
    repeat (3) tick();
    chk("reset_outputs1", int'({cs_n1, sclk1, data1, dc1, busy1, f1.wide_read, f1.nar_read}), 'b1000000);
    chk("reset_outputs3", int'({cs_n3, sclk3, data3, dc3, busy3, f3.wide_read, f3.nar_read}), 'b1000000);
    rst_n1 = 1'b1;
    rst_n3 = 1'b1;
    repeat (3) tick();
    chk("idle_outputs1", int'({cs_n1, sclk1, data1, busy1, f1.wide_read, f1.nar_read}), 'b100000);

    // Single narrow command word 0xA5.
    rd_before = rd1_cnt;
    nq1.push_back({1'b0, 8'hA5});
    sb_push(5'd8, 16'h00A5, 1'b0);
    wait_load1("t1_load", t0, hi);
    chk("t1_read_select", int'({f1.wide_read, f1.nar_read}), 'b01);
    chk("t1_cs_low_at_load", int'(cs_n1), 0);
    wait_cs_rise1("t1_cs", t, lf);
    chk("t1_shift_cycles", lf - t0, 16);
    chk("t1_cs_rise_delay", t - t0, 19);
    chk("t1_busy_idle", int'(busy1), 0);
    chk("t1_read_pulses", rd1_cnt - rd_before, 1);
    repeat (3) tick();

    // Wide has priority; narrow follows with no gap.
    rd_before = rd1_cnt;
    wq1.push_back(16'h1234);
    nq1.push_back({1'b1, 8'h2C});
    sb_push(5'd16, 16'h1234, 1'b1);
    sb_push(5'd8, 16'h002C, 1'b1);
    wait_load1("t2_load_a", t0, hi);
    chk("t2_wide_first", int'({f1.wide_read, f1.nar_read}), 'b10);
    wait_load1("t2_load_b", t1, hi);
    chk("t2_second_narrow", int'({f1.wide_read, f1.nar_read}), 'b01);
    chk("t2_load_spacing", t1 - t0, 32);
    chk("t2_cs_low_between", hi, 0);
    wait_cs_rise1("t2_cs", t, lf);
    chk("t2_cs_rise_delay", t - t1, 19);
    chk("t2_read_pulses", rd1_cnt - rd_before, 2);
    repeat (3) tick();

    // Re-arm from HOLD: a word arriving in the first HOLD cycle.
    nq1.push_back({1'b0, 8'h3A});
    sb_push(5'd8, 16'h003A, 1'b0);
    wait_load1("t3_load_a", t0, hi);
    while (cyc < t0 + 15) tick();
    nq1.push_back({1'b1, 8'h55});
    sb_push(5'd8, 16'h0055, 1'b1);
    wait_load1("t3_load_b", t1, hi);
    chk("t3_rearm_cycle", t1 - t0, 17);
    chk("t3_cs_low_in_hold", hi, 0);
    wait_cs_rise1("t3_cs", t, lf);
    chk("t3_cs_rise_delay", t - t1, 19);
    repeat (3) tick();

    // Reset during bit 5 of 0x1234 abandons the word.
    wq1.push_back(16'h1234);
    sb_push(5'd16, 16'h1234, 1'b1);
    wait_load1("t4_load", t0, hi);
    while (cyc < t0 + 10) tick();
    chk("t4_active_before_reset", int'({busy1, cs_n1, dc1}), 'b101);
    #1 rst_n1 = 1'b0;
    #1 chk("t4_async_reset", int'({cs_n1, sclk1, data1, dc1, busy1, f1.wide_read, f1.nar_read}), 'b1000000);
    tick();
    tick();
    rst_n1 = 1'b1;
    rd_before = rd1_cnt;
    repeat (10) tick();
    chk("t4_no_reread", rd1_cnt - rd_before, 0);
    chk("t4_idle_after", int'({busy1, cs_n1}), 'b01);

    // DIV=3 instance: 0xFFFF, 3-cycle phases, 96-cycle word.
    wq3.push_back(16'hFFFF);
    seen = 1'b0;
    t0   = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      if (f3.wide_read) begin
        seen = 1'b1;
        t0   = cyc;
      end
    end
    chk("t5_load_seen", int'(seen), 1);
    chk("t5_dc_wide", int'(dc3), 1);
    prev = sclk3;
    run  = 1;
    hmin = 999; hmax = 0; lmin = 999; lmax = 0;
    edges = 0; tend = 0; tcs = 0; cap = 16'h0; done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      tick();
      if (sclk3 == prev) begin
        run++;
      end else begin
        if (prev) begin
          if (run < hmin) hmin = run;
          if (run > hmax) hmax = run;
        end else begin
          if (run < lmin) lmin = run;
          if (run > lmax) lmax = run;
        end
        if (sclk3) begin
          edges++;
          cap = {cap[14:0], data3};
        end else begin
          tend = cyc;
        end
        prev = sclk3;
        run  = 1;
      end
      if (cs_n3) begin
        done = 1'b1;
        tcs  = cyc;
      end
    end
    chk("t5_cs_rise_seen", int'(done), 1);
    chk("t5_rising_edges", edges, 16);
    chk("t5_word", int'(cap), 'hFFFF);
    chk("t5_high_min", hmin, 3);
    chk("t5_high_max", hmax, 3);
    chk("t5_low_min", lmin, 3);
    chk("t5_low_max", lmax, 3);
    chk("t5_word_cycles", tend - t0, 96);
    chk("t5_cs_rise_delay", tcs - t0, 99);

    chk("sb_drained", sb_q.size(), 0);
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
